mac_unit: RTL and testbench
===========================

Name: mac_unit

Overview:
- Signed multiply-accumulate processing element (PE) for the 8x8 systolic array.
- Multiplies an incoming activation by an incoming weight and adds the product to the partial sum from the upstream PE.
- Registers the result for the downstream PE.
- Forwards activation east and weight south through one-cycle pipeline registers; includes zero-operand skip and enable gating for low power.

Parameters:
- DATA_W, 8, width of signed activation and weight operands.
- ACC_W, 24, width of signed partial-sum input/output; must satisfy ACC_W >= 2*DATA_W.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  global PE enable; 0 freezes all registers
- row_en  input  1  row enable; gates activation forwarding and MAC
- col_en  input  1  column enable; gates weight forwarding and MAC
- activation_in  input  DATA_W  signed activation from west neighbour
- weight_in  input  DATA_W  signed weight from north neighbour
- partial_sum_in  input  ACC_W  signed partial sum from upstream PE
- activation_out  output  DATA_W  registered activation to east neighbour
- weight_out  output  DATA_W  registered weight to south neighbour
- partial_sum_out  output  ACC_W  registered partial sum to downstream PE

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: on a rising clk edge with rst=1, activation_out, weight_out and partial_sum_out all become 0. Reset has priority over all enables.
- All outputs are registered; latency from inputs to outputs is exactly 1 clock. There is no combinational path from input to output.
- en=0: all three output registers hold their values, regardless of row_en, col_en or data inputs.
- en=1, row_en=1: activation_out <= activation_in. If row_en=0, activation_out holds.
- en=1, col_en=1: weight_out <= weight_in. If col_en=0, weight_out holds.
- en=1, row_en=1, col_en=1 (MAC active):
  - partial_sum_out <= partial_sum_in + sign_extend(activation_in * weight_in).
  - The product is a full 2*DATA_W signed product, sign-extended to ACC_W.
- en=1, row_en=1, col_en=1, and activation_in==0 or weight_in==0 (zero skip):
  - partial_sum_out <= partial_sum_in.
  - Multiplier operands are held at their previous value (operand isolation) so the multiplier does not toggle.
  - The result is identical to a normal MAC.
- en=1 with row_en=0 or col_en=0 (PE bypass): partial_sum_out <= partial_sum_in, so the sum chain is never broken by a masked PE.
- Overflow: without the optional feature, the addition wraps modulo 2^ACC_W (two's complement).
- The extreme product (-128 * -128 = 16384) fits in the product width and needs no special case.
- Reset asserted mid-stream clears all outputs on the next edge. The first cycle after rst deasserts behaves as a normal cycle.

Optional Feature:
- Macro: MAC_SATURATE_EN.
- Defined: the accumulation saturates.
  - Positive overflow clamps partial_sum_out to 2^(ACC_W-1)-1.
  - Negative overflow clamps it to -2^(ACC_W-1).
  - Overflow is detected from the operand and result sign bits.
  - Applies in MAC-active mode only; bypass and zero-skip pass partial_sum_in unchanged.
- Not defined: wrap-around two's-complement addition; no saturation logic is synthesized.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1, row_en=0, col_en=0 -> all outputs 0.
- Basic MAC: en=row_en=col_en=1, activation_in=3, weight_in=4, partial_sum_in=10 -> after 1 clk, partial_sum_out=22, activation_out=3, weight_out=4.
- Zero skip: activation_in=0, weight_in=5, partial_sum_in=50 -> partial_sum_out=50, weight_out=5, activation_out=0.
- Disable: en=0, activation_in=2, weight_in=3, partial_sum_in=100 -> partial_sum_out stays 50, activation_out stays 0, weight_out stays 5.
- Signed and bypass:
  - activation_in=-128, weight_in=-128, partial_sum_in=-5 -> partial_sum_out=16379.
  - Then col_en=0 with partial_sum_in=7 -> partial_sum_out=7 and weight_out holds -128.
- Overflow: partial_sum_in=8388607, activation_in=1, weight_in=1 -> partial_sum_out=-8388608 (wrap), or 8388607 with MAC_SATURATE_EN defined.

Source files
------------

// File: rtl/mac_unit.sv
// Signed multiply-accumulate PE for the systolic array: forwards activation east and weight south, adds a*w to the upstream partial sum.
// Optional macro MAC_SATURATE_EN: saturating accumulation instead of two's-complement wrap.
module mac_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     row_en,
  input  logic                     col_en,
  input  logic signed [DATA_W-1:0] activation_in,
  input  logic signed [DATA_W-1:0] weight_in,
  input  logic signed [ACC_W-1:0]  partial_sum_in,
  output logic signed [DATA_W-1:0] activation_out,
  output logic signed [DATA_W-1:0] weight_out,
  output logic signed [ACC_W-1:0]  partial_sum_out
);

  localparam int PROD_W = 2 * DATA_W;

  if (ACC_W < PROD_W) begin : g_bad_acc_w
    $error("mac_unit: ACC_W must be at least 2*DATA_W");
  end

  function automatic logic signed [ACC_W-1:0] acc_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic signed [ACC_W-1:0] s;
    s = a + b;
`ifdef MAC_SATURATE_EN
    // Same-sign operands producing an opposite-sign result means overflow.
    if ((a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1])) begin
      s = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
`endif
    return s;
  endfunction

  // ---- stage p0: operand isolation, multiply, accumulate (combinational)
  logic                     mac_p0;
  logic                     nz_p0;
  logic                     mul_p0;
  logic signed [DATA_W-1:0] opa_hold;
  logic signed [DATA_W-1:0] opb_hold;
  logic signed [DATA_W-1:0] mul_a_p0;
  logic signed [DATA_W-1:0] mul_b_p0;
  logic signed [PROD_W-1:0] a_ext_p0;
  logic signed [PROD_W-1:0] b_ext_p0;
  logic signed [PROD_W-1:0] prod_p0;
  logic signed [ACC_W-1:0]  prod_ext_p0;
  logic signed [ACC_W-1:0]  sum_p0;
  logic signed [ACC_W-1:0]  psum_next_p0;

  assign mac_p0 = en & row_en & col_en;
  assign nz_p0  = (activation_in != '0) && (weight_in != '0);
  assign mul_p0 = mac_p0 & nz_p0;

  // The multiplier sees the last useful operands unless a real product is needed.
  assign mul_a_p0    = mul_p0 ? activation_in : opa_hold;
  assign mul_b_p0    = mul_p0 ? weight_in     : opb_hold;
  assign a_ext_p0    = PROD_W'(mul_a_p0);
  assign b_ext_p0    = PROD_W'(mul_b_p0);
  assign prod_p0     = a_ext_p0 * b_ext_p0;
  assign prod_ext_p0 = ACC_W'(prod_p0);
  assign sum_p0      = acc_add(partial_sum_in, prod_ext_p0);
  assign psum_next_p0 = mul_p0 ? sum_p0 : partial_sum_in;

  always_ff @(posedge clk) begin
    if (mul_p0) begin
      opa_hold <= activation_in;
      opb_hold <= weight_in;
    end
  end

  // ---- stage p1: output registers toward east/south/downstream neighbours
  logic signed [DATA_W-1:0] act_p1;
  logic signed [DATA_W-1:0] wgt_p1;
  logic signed [ACC_W-1:0]  psum_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      act_p1  <= '0;
      wgt_p1  <= '0;
      psum_p1 <= '0;
    end else if (en) begin
      if (row_en) act_p1 <= activation_in;
      if (col_en) wgt_p1 <= weight_in;
      psum_p1 <= psum_next_p0;
    end
  end

  assign activation_out  = act_p1;
  assign weight_out      = wgt_p1;
  assign partial_sum_out = psum_p1;

endmodule

// File: tb/tb_mac_unit.sv
// Self-checking bench for mac_unit: directed vector table, then a randomized run against a behavioural model.
module tb_mac_unit;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 24;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     en;
  logic                     row_en;
  logic                     col_en;
  logic signed [DATA_W-1:0] activation_in;
  logic signed [DATA_W-1:0] weight_in;
  logic signed [ACC_W-1:0]  partial_sum_in;
  logic signed [DATA_W-1:0] activation_out;
  logic signed [DATA_W-1:0] weight_out;
  logic signed [ACC_W-1:0]  partial_sum_out;

  mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .row_en          (row_en),
    .col_en          (col_en),
    .activation_in   (activation_in),
    .weight_in       (weight_in),
    .partial_sum_in  (partial_sum_in),
    .activation_out  (activation_out),
    .weight_out      (weight_out),
    .partial_sum_out (partial_sum_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, en, row, col;
    logic signed [DATA_W-1:0] a, w;
    logic signed [ACC_W-1:0]  ps;
    logic signed [DATA_W-1:0] ea, ew;
    logic signed [ACC_W-1:0]  eps;
  } vec_t;

  typedef struct {
    string                    name;
    logic signed [DATA_W-1:0] ea, ew;
    logic signed [ACC_W-1:0]  eps;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  localparam int PMAX = (1 << (ACC_W-1)) - 1;
  localparam int PMIN = -(1 << (ACC_W-1));

  function automatic vec_t mk(input bit r, e, ro, co, input int a, w, ps, ea, ew, eps);
    vec_t v;
    v.rst = r; v.en = e; v.row = ro; v.col = co;
    v.a = DATA_W'(a); v.w = DATA_W'(w); v.ps = ACC_W'(ps);
    v.ea = DATA_W'(ea); v.ew = DATA_W'(ew); v.eps = ACC_W'(eps);
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  // Drive one cycle, queue its expectation, then compare after the edge.
  task automatic step(input bit r, e, ro, co,
                      input logic signed [DATA_W-1:0] a, w,
                      input logic signed [ACC_W-1:0] ps,
                      input exp_t ex);
    exp_t got;
    rst = r; en = e; row_en = ro; col_en = co;
    activation_in = a; weight_in = w; partial_sum_in = ps;
    sb.push_back(ex);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({ex.name, "_sb_empty"}, 0, 1);
    end else begin
      got = sb.pop_front();
      check({got.name, "_act"},  activation_out,  got.ea);
      check({got.name, "_wgt"},  weight_out,      got.ew);
      check({got.name, "_psum"}, partial_sum_out, got.eps);
    end
  endtask

  initial begin
    exp_t ex;
    logic signed [DATA_W-1:0] m_act, m_wgt, ra, rw;
    logic signed [ACC_W-1:0]  m_ps, rps;
    longint s;
    bit r, e, ro, co;
    int ovf_exp, novf_exp;

`ifdef MAC_SATURATE_EN
    ovf_exp  = PMAX;
    novf_exp = PMIN;
`else
    ovf_exp  = PMIN;
    novf_exp = PMAX;
`endif

    rst = 1'b1; en = 1'b1; row_en = 1'b0; col_en = 1'b0;
    activation_in = '0; weight_in = '0; partial_sum_in = '0;

    vecs.push_back(mk(1, 1, 0, 0,    7,    9,     33,    0,    0,     0));
    vecs.push_back(mk(1, 1, 0, 0,    7,    9,     33,    0,    0,     0));
    vecs.push_back(mk(0, 1, 1, 1,    3,    4,     10,    3,    4,    22));
    vecs.push_back(mk(0, 1, 1, 1,    0,    5,     50,    0,    5,    50));
    vecs.push_back(mk(0, 0, 1, 1,    2,    3,    100,    0,    5,    50));
    vecs.push_back(mk(0, 1, 1, 1, -128, -128,     -5, -128, -128, 16379));
    vecs.push_back(mk(0, 1, 1, 0,    9,   11,      7,    9, -128,     7));
    vecs.push_back(mk(0, 1, 0, 1,    1,    2,    -20,    9,    2,   -20));
    vecs.push_back(mk(0, 1, 1, 1,   -3,    0,  -1000,   -3,    0, -1000));
    vecs.push_back(mk(0, 1, 1, 1,   -7,    6,      0,   -7,    6,   -42));
    vecs.push_back(mk(0, 1, 1, 1,    1,    1,   PMAX,    1,    1, ovf_exp));
    vecs.push_back(mk(0, 1, 1, 1,   -1,    1,   PMIN,   -1,    1, novf_exp));
    vecs.push_back(mk(0, 1, 1, 1,    0,    1,   PMAX,    0,    1,  PMAX));
    vecs.push_back(mk(0, 1, 1, 1,  127, -128, -16000,  127, -128, -32256));
    vecs.push_back(mk(1, 0, 1, 1,    4,    4,    400,    0,    0,     0));
    vecs.push_back(mk(0, 1, 1, 1,    5,    5,      1,    5,    5,    26));

    for (int i = 0; i < vecs.size(); i++) begin
      ex.name = $sformatf("vec%0d", i);
      ex.ea = vecs[i].ea; ex.ew = vecs[i].ew; ex.eps = vecs[i].eps;
      step(vecs[i].rst, vecs[i].en, vecs[i].row, vecs[i].col,
           vecs[i].a, vecs[i].w, vecs[i].ps, ex);
    end

    // Zero skip must not disturb the following real product.
    ex.name = "skip_then_mac_a"; ex.ea = 0; ex.ew = 9; ex.eps = 77;
    step(0, 1, 1, 1, 0, 9, 77, ex);
    ex.name = "skip_then_mac_b"; ex.ea = -2; ex.ew = 9; ex.eps = 59;
    step(0, 1, 1, 1, -2, 9, 77, ex);

    m_act = -2; m_wgt = 9; m_ps = 59;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 39) == 0);
      e  = ($urandom_range(0, 7) != 0);
      ro = ($urandom_range(0, 3) != 0);
      co = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0:       ra = '0;
        1:       ra = -128;
        default: ra = DATA_W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       rw = '0;
        1:       rw = 127;
        default: rw = DATA_W'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       rps = (i % 2 == 0) ? ACC_W'(PMAX - $urandom_range(0, 20000))
                                    : ACC_W'(PMIN + $urandom_range(0, 20000));
        default: rps = ACC_W'($urandom);
      endcase

      if (r) begin
        m_act = '0; m_wgt = '0; m_ps = '0;
      end else if (e) begin
        if (ro) m_act = ra;
        if (co) m_wgt = rw;
        if (ro && co) begin
          s = longint'(rps) + longint'(ra) * longint'(rw);
`ifdef MAC_SATURATE_EN
          if (s > PMAX) s = PMAX;
          if (s < PMIN) s = PMIN;
`endif
          m_ps = s[ACC_W-1:0];
        end else begin
          m_ps = rps;
        end
      end
      ex.name = $sformatf("rnd%0d", i);
      ex.ea = m_act; ex.ew = m_wgt; ex.eps = m_ps;
      step(r, e, ro, co, ra, rw, rps, ex);
    end

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
